// File: rtl/instr_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instr_stream_loader
//  Description : Streams N 32-bit words from a synchronous-read word source as
//                a gap-free byte stream: START marker, 4 bytes/word MSB first,
//                STOP marker.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_stream_loader #(
    parameter int         AW         = 6,
    parameter logic [7:0] IDLE_BYTE  = 8'h00,
    parameter logic [7:0] START_BYTE = 8'hFE,
    parameter logic [7:0] STOP_BYTE  = 8'hFF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic [AW:0]   num_words_i,
    output logic [AW-1:0] rd_addr_o,
    input  logic [31:0]   rd_data_i,
    output logic [7:0]    instr_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    localparam logic [AW:0]   c_DEPTH    = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   c_CNT_ZERO = '0;
    localparam logic [AW:0]   c_CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] c_ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [7:0]    c_SUB_BYTE = 8'h00;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_SOF   = 3'd2,
        S_DATA  = 3'd3,
        S_EOF   = 3'd4
    } state_t;

    state_t        r_state,      w_state_nxt;
    logic [7:0]    r_instr,      w_instr_nxt;
    logic [AW-1:0] r_rd_addr,    w_rd_addr_nxt;
    logic          r_busy,       w_busy_nxt;
    logic          r_done,       w_done_nxt;
    logic          r_err,        w_err_nxt;
    logic [31:0]   r_shift,      w_shift_nxt;
    logic [1:0]    r_byte_cnt,   w_byte_cnt_nxt;
    logic [AW:0]   r_count,      w_count_nxt;
    logic [AW:0]   r_words_left, w_words_left_nxt;

    logic [AW:0]   w_count_clamped;
    logic [7:0]    w_raw_byte;
    logic          w_stop_hit;
    logic [7:0]    w_data_byte;

    assign w_count_clamped = (num_words_i > c_DEPTH) ? c_DEPTH : num_words_i;

    // Next data byte comes from the shift register mid-word, otherwise from the
    // freshly returned source word that is being loaded on this edge.
    assign w_raw_byte  = (r_state == S_DATA && r_byte_cnt != 2'd3) ? r_shift[31:24]
                                                                  : rd_data_i[31:24];
    assign w_stop_hit  = (w_raw_byte == STOP_BYTE);
    assign w_data_byte = w_stop_hit ? c_SUB_BYTE : w_raw_byte;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_instr      <= IDLE_BYTE;
            r_rd_addr    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_shift      <= '0;
            r_byte_cnt   <= '0;
            r_count      <= '0;
            r_words_left <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_instr      <= w_instr_nxt;
            r_rd_addr    <= w_rd_addr_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
            r_shift      <= w_shift_nxt;
            r_byte_cnt   <= w_byte_cnt_nxt;
            r_count      <= w_count_nxt;
            r_words_left <= w_words_left_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_instr_nxt      = r_instr;
        w_rd_addr_nxt    = r_rd_addr;
        w_busy_nxt       = r_busy;
        w_done_nxt       = 1'b0;
        w_err_nxt        = r_err;
        w_shift_nxt      = r_shift;
        w_byte_cnt_nxt   = r_byte_cnt;
        w_count_nxt      = r_count;
        w_words_left_nxt = r_words_left;

        case (r_state)
            S_IDLE: begin
                w_instr_nxt = IDLE_BYTE;
                if (start_i) begin
                    w_state_nxt   = S_FETCH;
                    w_count_nxt   = w_count_clamped;
                    w_rd_addr_nxt = '0;
                    w_err_nxt     = 1'b0;
                    w_busy_nxt    = 1'b1;
                end
            end

            S_FETCH: begin
                w_instr_nxt = START_BYTE;
                w_state_nxt = S_SOF;
            end

            S_SOF: begin
                if (r_count == c_CNT_ZERO) begin
                    w_instr_nxt = STOP_BYTE;
                    w_state_nxt = S_EOF;
                end else begin
                    w_instr_nxt      = w_data_byte;
                    w_err_nxt        = r_err | w_stop_hit;
                    w_shift_nxt      = {rd_data_i[23:0], 8'h00};
                    w_byte_cnt_nxt   = 2'd0;
                    w_words_left_nxt = r_count - c_CNT_ONE;
                    w_state_nxt      = S_DATA;
                    // Address word 1 only when it exists.
                    if (r_count > c_CNT_ONE) begin
                        w_rd_addr_nxt = c_ADDR_ONE;
                    end
                end
            end

            S_DATA: begin
                if (r_byte_cnt != 2'd3) begin
                    w_instr_nxt    = w_data_byte;
                    w_err_nxt      = r_err | w_stop_hit;
                    w_shift_nxt    = {r_shift[23:0], 8'h00};
                    w_byte_cnt_nxt = r_byte_cnt + 2'd1;
                end else if (r_words_left == c_CNT_ZERO) begin
                    w_instr_nxt = STOP_BYTE;
                    w_state_nxt = S_EOF;
                end else begin
                    w_instr_nxt      = w_data_byte;
                    w_err_nxt        = r_err | w_stop_hit;
                    w_shift_nxt      = {rd_data_i[23:0], 8'h00};
                    w_byte_cnt_nxt   = 2'd0;
                    w_words_left_nxt = r_words_left - c_CNT_ONE;
                    // Prefetch the following word, but never beyond the last one.
                    if (r_words_left > c_CNT_ONE) begin
                        w_rd_addr_nxt = r_rd_addr + c_ADDR_ONE;
                    end
                end
            end

            S_EOF: begin
                w_instr_nxt = IDLE_BYTE;
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_instr_nxt = IDLE_BYTE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign rd_addr_o = r_rd_addr;
    assign instr_o   = r_instr;
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign err_o     = r_err;

endmodule
`default_nettype wire
